// File: rtl/im_arb_pkg.sv
// im_arb_pkg: shared constants for the instruction-memory port arbiter.
//   ST_*       FSM state encodings (legacy-compatible localparams)
//   PORT_F/L   grant encodings (gnt_l value of each requester)
//   ALIGN_MASK mask applied to the two low address bits to word-align IM_ADDR
package im_arb_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_ADDR = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_CAPT = 3'd3;
  localparam logic [2:0] ST_ACK  = 3'd4;
  localparam logic [2:0] ST_REL  = 3'd5;

  localparam logic PORT_F = 1'b0;
  localparam logic PORT_L = 1'b1;

  localparam logic [1:0] ALIGN_MASK = 2'b00;

endpackage

// File: rtl/im_port_arbiter_req_sync.sv
// req_sync: STG-deep asynchronous-reset flop chain bringing a 4-phase request
// into the IM_CLK domain.
//   clk_i   destination clock
//   rst_ni  asynchronous active-low reset (chain clears to 0)
//   req_i   asynchronous request level
//   req_o   synchronized request level (STG edges of latency)
module req_sync #(
  parameter int unsigned STG = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic req_i,
  output logic req_o
);

  logic [STG-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STG-2:0], req_i};
    end
  end

  assign req_o = sync_q[STG-1];

endmodule

// File: rtl/im_port_arbiter.sv
// im_port_arbiter: shares a synchronous instruction-memory port between the
// fetch requester (F) and the debug/loader requester (L). Both use 4-phase
// bundled-data read handshakes; requests are synchronized, arbitrated
// round-robin and served with one memory read per grant.
//   IM_CLK              arbiter / memory clock
//   Z_R                 asynchronous active-low reset
//   f_R/f_addr/f_A/f_data  fetch handshake, address and returned word
//   l_R/l_addr/l_A/l_data  loader handshake, address and returned word
//   IM_ADDR / IM_DATA   word-aligned memory address and read data
//   busy                high whenever the FSM is not idle
//   gnt_l               current/last grant (0 = F, 1 = L)
module im_port_arbiter
  import im_arb_pkg::*;
#(
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32,
  parameter int unsigned SYNC_STG = 2,
  parameter int unsigned MEM_LAT  = 1
) (
  input  logic          IM_CLK,
  input  logic          Z_R,
  input  logic          f_R,
  input  logic [AW-1:0] f_addr,
  output logic          f_A,
  output logic [DW-1:0] f_data,
  input  logic          l_R,
  input  logic [AW-1:0] l_addr,
  output logic          l_A,
  output logic [DW-1:0] l_data,
  output logic [AW-1:0] IM_ADDR,
  input  logic [DW-1:0] IM_DATA,
  output logic          busy,
  output logic          gnt_l
);

  localparam int unsigned CW = 3;

  logic          fs, ls;
  logic [2:0]    state_q, state_d;
  logic          gnt_q, gnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          fa_q, fa_d, la_q, la_d;
  logic [DW-1:0] fdata_q, fdata_d, ldata_q, ldata_d;
  logic          win_req;
  logic [AW-1:0] win_addr;

  req_sync #(.STG(SYNC_STG)) u_sync_f (
    .clk_i (IM_CLK),
    .rst_ni(Z_R),
    .req_i (f_R),
    .req_o (fs)
  );

  req_sync #(.STG(SYNC_STG)) u_sync_l (
    .clk_i (IM_CLK),
    .rst_ni(Z_R),
    .req_i (l_R),
    .req_o (ls)
  );

  // gnt_q holds the winner from IDLE onwards, so it selects the active channel.
  assign win_req  = (gnt_q == PORT_L) ? ls : fs;
  assign win_addr = (gnt_q == PORT_L) ? l_addr : f_addr;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    fa_d    = fa_q;
    la_d    = la_q;
    fdata_d = fdata_q;
    ldata_d = ldata_q;
    case (state_q)
      ST_IDLE: begin
        if (fs || ls) begin
          // Tie goes to the port that did not win last time.
          gnt_d   = (fs && ls) ? ~gnt_q : ls;
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        addr_d  = {win_addr[AW-1:2], win_addr[1:0] & ALIGN_MASK};
        cnt_d   = CW'(MEM_LAT - 1);
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_CAPT;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_CAPT: begin
        if (gnt_q == PORT_L) begin
          ldata_d = IM_DATA;
          la_d    = 1'b1;
        end else begin
          fdata_d = IM_DATA;
          fa_d    = 1'b1;
        end
        state_d = ST_ACK;
      end
      ST_ACK: begin
        // Acknowledge is withdrawn on the ACK->REL edge so that it falls
        // SYNC_STG+1 edges after R and lasts one cycle if R was dropped early;
        // REL is then a pure turnaround cycle with A already low.
        if (!win_req) begin
          fa_d    = 1'b0;
          la_d    = 1'b0;
          state_d = ST_REL;
        end
      end
      ST_REL: begin
        fa_d    = 1'b0;
        la_d    = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge IM_CLK or negedge Z_R) begin
    if (!Z_R) begin
      state_q <= ST_IDLE;
      gnt_q   <= PORT_L;
      addr_q  <= '0;
      cnt_q   <= '0;
      fa_q    <= 1'b0;
      la_q    <= 1'b0;
      fdata_q <= '0;
      ldata_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      fa_q    <= fa_d;
      la_q    <= la_d;
      fdata_q <= fdata_d;
      ldata_q <= ldata_d;
    end
  end

  assign f_A     = fa_q;
  assign l_A     = la_q;
  assign f_data  = fdata_q;
  assign l_data  = ldata_q;
  assign IM_ADDR = addr_q;
  assign busy    = (state_q != ST_IDLE);
  assign gnt_l   = gnt_q;

endmodule

// File: tb/tb_im_port_arbiter.sv
module tb_im_port_arbiter;

  typedef struct {
    logic        port;
    logic [31:0] addr;
    logic [31:0] exp_ia;
    logic [31:0] exp_d;
  } vec_t;

  logic        clk = 1'b0;
  logic        z_r;
  logic        f_R, l_R, f_A, l_A, busy, gnt_l;
  logic [31:0] f_addr, l_addr, f_data, l_data, im_addr, im_data;
  logic        f3_R, l3_R, f3_A, l3_A, busy3, gnt3;
  logic [31:0] f3_addr, l3_addr, f3_data, l3_data, im_addr3, im_data3;
  logic [31:0] p1, p2, p3;

  logic [31:0] mem [0:63];
  logic [31:0] last_data [2];
  logic        last_gnt;
  logic        order_q [$];
  int unsigned total = 0;
  int unsigned bad   = 0;
  vec_t        vecs [6];

  always #5 clk = ~clk;

  im_port_arbiter #(.AW(32), .DW(32), .SYNC_STG(2), .MEM_LAT(1)) u_dut (
    .IM_CLK(clk), .Z_R(z_r),
    .f_R(f_R), .f_addr(f_addr), .f_A(f_A), .f_data(f_data),
    .l_R(l_R), .l_addr(l_addr), .l_A(l_A), .l_data(l_data),
    .IM_ADDR(im_addr), .IM_DATA(im_data), .busy(busy), .gnt_l(gnt_l)
  );

  im_port_arbiter #(.AW(32), .DW(32), .SYNC_STG(2), .MEM_LAT(3)) u_dut3 (
    .IM_CLK(clk), .Z_R(z_r),
    .f_R(f3_R), .f_addr(f3_addr), .f_A(f3_A), .f_data(f3_data),
    .l_R(l3_R), .l_addr(l3_addr), .l_A(l3_A), .l_data(l3_data),
    .IM_ADDR(im_addr3), .IM_DATA(im_data3), .busy(busy3), .gnt_l(gnt3)
  );

  // Synchronous memories: 1-edge read for u_dut, 3-edge pipeline for u_dut3.
  always_ff @(posedge clk) begin
    im_data <= mem[im_addr[7:2]];
    p1      <= mem[im_addr3[7:2]];
    p2      <= p1;
    p3      <= p2;
  end
  assign im_data3 = p3;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic do_req(input logic port, input logic [31:0] addr, input logic [31:0] exp_ia,
                        input logic [31:0] exp_d, input string tag);
    int unsigned n;
    logic        other_seen;
    @(negedge clk);
    if (port) begin l_R = 1'b1; l_addr = addr; end
    else      begin f_R = 1'b1; f_addr = addr; end
    n = 0;
    other_seen = 1'b0;
    do begin
      @(posedge clk); #1; n++;
      if ((port ? f_A : l_A) === 1'b1) other_seen = 1'b1;
    end while ((port ? l_A : f_A) !== 1'b1 && n < 40);
    chk({tag, "_rise"}, n, 6);
    chk({tag, "_data"}, port ? l_data : f_data, exp_d);
    chk({tag, "_imaddr"}, im_addr, exp_ia);
    chk({tag, "_gnt"}, gnt_l, port);
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_otherA"}, other_seen, 0);
    chk({tag, "_hold"}, port ? f_data : l_data, last_data[!port]);
    last_data[port] = exp_d;
    last_gnt = port;
    if (port) l_R = 1'b0; else f_R = 1'b0;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while ((port ? l_A : f_A) !== 1'b0 && n < 40);
    chk({tag, "_fall"}, n, 3);
    chk({tag, "_keep"}, port ? l_data : f_data, exp_d);
    @(posedge clk); #1;
    chk({tag, "_idle"}, busy, 0);
  endtask

  task automatic agent(input logic port, input int unsigned cnt);
    logic [31:0] a;
    int unsigned n;
    for (int unsigned k = 0; k < cnt; k++) begin
      a = $urandom;
      if (port) begin l_R = 1'b1; l_addr = a; end
      else      begin f_R = 1'b1; f_addr = a; end
      n = 0;
      while ((port ? l_A : f_A) !== 1'b1 && n < 60) begin
        @(posedge clk); #1; n++;
      end
      chk(port ? "cont_L_wait" : "cont_F_wait", n < 60, 1);
      order_q.push_back(port);
      chk(port ? "cont_L_data" : "cont_F_data", port ? l_data : f_data, mem[a[7:2]]);
      last_data[port] = mem[a[7:2]];
      if (port) l_R = 1'b0; else f_R = 1'b0;
      n = 0;
      while ((port ? l_A : f_A) !== 1'b0 && n < 60) begin
        @(posedge clk); #1; n++;
      end
    end
  endtask

  task automatic req3(input logic [31:0] addr, input string tag);
    int unsigned n;
    @(negedge clk);
    f3_R = 1'b1; f3_addr = addr;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (f3_A !== 1'b1 && n < 40);
    chk({tag, "_rise"}, n, 8);
    chk({tag, "_data"}, f3_data, mem[addr[7:2]]);
    chk({tag, "_imaddr"}, im_addr3, addr & 32'hFFFF_FFFC);
    chk({tag, "_lA"}, {l3_A, gnt3}, 0);
    chk({tag, "_ldata"}, l3_data, 0);
    f3_R = 1'b0;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (f3_A !== 1'b0 && n < 40);
    chk({tag, "_fall"}, n, 3);
    @(posedge clk); #1;
    chk({tag, "_idle"}, busy3, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n;
    logic [31:0] a;
    logic        first;

    for (int i = 0; i < 64; i++) mem[i] = 32'hC0DE_0000 + 32'(i);
    mem[4] = 32'h2002_0005;

    vecs[0] = '{1'b0, 32'h0000_0010, 32'h0000_0010, 32'h2002_0005};
    vecs[1] = '{1'b1, 32'h0000_0013, 32'h0000_0010, 32'h2002_0005};
    vecs[2] = '{1'b0, 32'h1234_5624, 32'h1234_5624, 32'hC0DE_0009};
    vecs[3] = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'hC0DE_003F};
    vecs[4] = '{1'b0, 32'h0000_0003, 32'h0000_0000, 32'hC0DE_0000};
    vecs[5] = '{1'b1, 32'h8000_0081, 32'h8000_0080, 32'hC0DE_0020};

    // T1: reset held with a fetch request pending.
    z_r = 1'b0;
    f_R = 1'b1; f_addr = 32'h0000_0010;
    l_R = 1'b0; l_addr = '0;
    f3_R = 1'b0; f3_addr = '0; l3_R = 1'b0; l3_addr = '0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("rst_fA", f_A, 0);
    chk("rst_lA", l_A, 0);
    chk("rst_imaddr", im_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_gnt", gnt_l, 1);
    chk("rst_data", {f_data | l_data}, 0);
    z_r = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (f_A !== 1'b1 && n < 40);
    chk("t1_rise", n, 6);
    chk("t1_data", f_data, 32'h2002_0005);
    chk("t1_gnt", gnt_l, 0);
    f_R = 1'b0;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (f_A !== 1'b0 && n < 40);
    chk("t1_fall", n, 3);
    @(posedge clk); #1;
    last_data[0] = 32'h2002_0005;
    last_data[1] = '0;
    last_gnt = 1'b0;

    // T2/T3 and further directed single-port vectors.
    for (int unsigned i = 0; i < 6; i++) begin
      do_req(vecs[i].port, vecs[i].addr, vecs[i].exp_ia, vecs[i].exp_d, $sformatf("vec%0d", i));
    end

    // Random single-port transactions against the memory model.
    for (int unsigned i = 0; i < 16; i++) begin
      a = $urandom;
      do_req(1'($urandom_range(0, 1)), a, a & 32'hFFFF_FFFC, mem[a[7:2]], $sformatf("rnd%0d", i));
    end

    // T4: both ports request on the same edge and re-request immediately.
    first = !last_gnt;
    order_q.delete();
    @(negedge clk);
    fork
      agent(1'b0, 4);
      agent(1'b1, 4);
    join
    chk("cont_count", order_q.size(), 8);
    for (int unsigned i = 0; i < order_q.size(); i++) begin
      chk($sformatf("cont_order%0d", i), order_q[i], first ^ i[0]);
    end
    if (order_q.size() > 0) last_gnt = order_q[order_q.size() - 1];
    repeat (3) @(posedge clk);
    #1;
    chk("cont_idle", busy, 0);

    // T5: reset while the fetch acknowledge is high.
    @(negedge clk);
    f_R = 1'b1; f_addr = 32'h0000_0038;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (f_A !== 1'b1 && n < 40);
    chk("t5_rise", n, 6);
    #2;
    z_r = 1'b0;
    #1;
    chk("t5_fA", f_A, 0);
    chk("t5_busy", busy, 0);
    chk("t5_gnt", gnt_l, 1);
    chk("t5_fdata", f_data, 0);
    f_R = 1'b0;
    repeat (2) @(negedge clk);
    z_r = 1'b1;
    last_data[0] = '0;
    last_data[1] = '0;
    do_req(1'b0, 32'h0000_0038, 32'h0000_0038, 32'hC0DE_000E, "t5_after");

    // T6: MEM_LAT=3 build; stale pipeline contents must be ignored.
    req3(32'h0000_0024, "t6a");
    req3(32'h0000_00B8, "t6b");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
